decode_unit: RTL and testbench
==============================

# decode_unit

RV32I instruction decoder for the core's decode stage, between instruction fetch and register-file read/execute. Takes one 32-bit instruction word per cycle and splits it into register indices, function fields, a sign-extended immediate and execute/memory control strobes. Outputs are registered, so decode costs one pipeline cycle. Unsupported encodings are flagged rather than silently executed.

## Interface
- No parameters. XLEN fixed at 32.
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction word.
- inst_valid  in  1  inst holds a real instruction this cycle.
- valid_o  out  1  registered copy of inst_valid.
- opcode  out  7  inst[6:0].
- rd  out  5  inst[11:7].
- funct3  out  3  inst[14:12].
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- funct7  out  7  inst[31:25].
- imm  out  32  sign-extended immediate for the decoded format.
- fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, none=7.
- alu_op  out  5  operation code, defined under Operation.
- alu_src_imm  out  1  ALU operand B is imm; 0 means operand B is rs2.
- reg_write  out  1  instruction writes rd.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  conditional branch.
- jump  out  1  JAL or JALR.
- illegal  out  1  encoding not supported.

## Operation
- Raw fields (opcode, rd, funct3, rs1, rs2, funct7) are always sliced from inst, independent of opcode.
- Immediates, with bit 31 sign-extended:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and none formats: imm = 0.
- alu_op encoding:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - M extension: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- Per-opcode decode:
  - 0x37 LUI: U, PASS_B, alu_src_imm, reg_write.
  - 0x17 AUIPC: U, ADD, alu_src_imm, reg_write.
  - 0x6F JAL: J, jump, reg_write.
  - 0x67 JALR: I, jump, reg_write, ADD, alu_src_imm. funct3 must be 0.
  - 0x63 BRANCH: B, branch. funct3 2 and 3 are illegal. alu_op SUB for BEQ/BNE; SLT for BLT/BGE; SLTU for BLTU/BGEU.
  - 0x03 LOAD: I, mem_read, reg_write, ADD, alu_src_imm. Legal funct3 only 0, 1, 2, 4, 5.
  - 0x23 STORE: S, mem_write, ADD, alu_src_imm. Legal funct3 only 0, 1, 2.
  - 0x13 OP-IMM: I, reg_write, alu_src_imm; alu_op from funct3.
    - SLLI requires funct7 = 0.
    - SRLI/SRAI require funct7 = 0x00 or 0x20; 0x20 selects SRA.
  - 0x33 OP: R, reg_write; alu_op from funct3.
    - funct7 0x00 selects the base op.
    - funct7 0x20 is legal only with funct3 0 (SUB) or 5 (SRA).
    - funct7 0x01: see Configuration.
  - 0x0F FENCE and 0x73 ECALL/EBREAK (inst[31:7] = 0 or 0x2000): fmt none, all strobes 0, not illegal.
- Any other encoding:
  - illegal = 1.
  - reg_write, mem_read, mem_write, branch and jump forced to 0.
  - alu_op 0, fmt 7.
- inst_valid = 0:
  - All strobes and illegal register as 0.
  - Fields and imm still register normally.

## Timing
- All outputs are flops updated on the rising edge of clk. Latency is exactly one cycle, inst to outputs.
- Accepts a new instruction every cycle. No stall or backpressure.
- Reset (asynchronous, immediate, including mid-stream):
  - Every output goes to 0: valid_o 0, imm 0, alu_op 0 (ADD), illegal 0.
  - Exception: fmt resets to 7.
- First edge after rst deasserts captures inst normally.

## Configuration
- DECODE_M_EXT_EN defined: OP with funct7 0x01 decodes as RV32M.
  - funct3 0..7 map to alu_op 16..23.
  - R format, reg_write.
- DECODE_M_EXT_EN undefined: funct7 0x01 on OP is illegal. alu_op values 16..23 are never produced.

## Test plan
- 0x002081B3 (ADD x3,x1,x2):
  - Next cycle: rd 3, rs1 1, rs2 2, funct7 0, fmt 0, alu_op 0.
  - reg_write 1, alu_src_imm 0, imm 0.
- 0x05408113 (ADDI x2,x1,0x54): rd 2, rs1 1, imm 0x00000054, fmt 1, alu_src_imm 1, reg_write 1.
- 0x000230B7 (LUI x1,0x23): rd 1, imm 0x00023000, alu_op 10, fmt 4.
- 0xFE111CE3 (BNE x2,x1):
  - rs1 2, rs2 1, funct3 1, imm 0xFFFFFFF8.
  - branch 1, reg_write 0.
- 0xFF9FF26F (JAL x4): rd 4, imm 0xFFFFFFF8, jump 1, reg_write 1, fmt 5.
- 0x40110233 (SUB x4,x2,x1): funct7 0x20, alu_op 1.
- Error, disable and reset cases:
  - 0x02110233 gives illegal 1 without DECODE_M_EXT_EN, and alu_op 16 (MUL) with it.
  - Opcode 0x7F gives illegal 1 with all strobes 0.
  - inst_valid 0 gives all strobes 0.
  - rst asserted mid-stream clears all outputs within the same cycle.

Source files
------------

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - RV32I instruction decoder, registered outputs; DECODE_M_EXT_EN enables RV32M decode on OP
module decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        valid_o,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [2:0]  fmt,
    output logic [4:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        illegal
);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Base integer op selected by funct3; alt picks SUB/SRA where they exist
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        op = ALU_ADD;
        case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  f_opc;
    logic [2:0]  f_f3;
    logic [6:0]  f_f7;

    logic [2:0]  d_fmt;
    logic [4:0]  d_alu_op;
    logic        d_src_imm;
    logic        d_reg_write;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_branch;
    logic        d_jump;
    logic        d_illegal;
    logic [31:0] d_imm;

    assign f_opc = inst[6:0];
    assign f_f3  = inst[14:12];
    assign f_f7  = inst[31:25];

    // Opcode/function decode into format, ALU op and control strobes
    always_comb begin
        d_fmt       = FMT_NONE;
        d_alu_op    = ALU_ADD;
        d_src_imm   = 1'b0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;

        case (f_opc)
            OPC_LUI: begin
                d_fmt       = FMT_U;
                d_alu_op    = ALU_PASS_B;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                d_fmt       = FMT_U;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JAL: begin
                d_fmt       = FMT_J;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JALR: begin
                d_fmt       = FMT_I;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_src_imm   = 1'b1;
                d_illegal   = (f_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                d_fmt    = FMT_B;
                d_branch = 1'b1;
                case (f_f3)
                    3'd0, 3'd1: d_alu_op = ALU_SUB;
                    3'd4, 3'd5: d_alu_op = ALU_SLT;
                    3'd6, 3'd7: d_alu_op = ALU_SLTU;
                    default:    d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_fmt       = FMT_I;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_src_imm   = 1'b1;
                d_illegal   = (f_f3 == 3'd3) || (f_f3 == 3'd6) || (f_f3 == 3'd7);
            end
            OPC_STORE: begin
                d_fmt       = FMT_S;
                d_mem_write = 1'b1;
                d_src_imm   = 1'b1;
                d_illegal   = (f_f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                d_fmt       = FMT_I;
                d_reg_write = 1'b1;
                d_src_imm   = 1'b1;
                // funct7 only qualifies the shift forms; other funct3 use those bits as immediate
                d_alu_op    = base_alu(f_f3, (f_f3 == 3'd5) && (f_f7 == F7_ALT));
                if (f_f3 == 3'd1) begin
                    d_illegal = (f_f7 != F7_BASE);
                end else if (f_f3 == 3'd5) begin
                    d_illegal = (f_f7 != F7_BASE) && (f_f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                d_fmt       = FMT_R;
                d_reg_write = 1'b1;
                if (f_f7 == F7_BASE) begin
                    d_alu_op = base_alu(f_f3, 1'b0);
                end else if (f_f7 == F7_ALT) begin
                    d_alu_op  = base_alu(f_f3, 1'b1);
                    d_illegal = (f_f3 != 3'd0) && (f_f3 != 3'd5);
`ifdef DECODE_M_EXT_EN
                end else if (f_f7 == F7_MULDIV) begin
                    d_alu_op = {2'b10, f_f3};
`endif
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                d_fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK are supported; CSR and other SYSTEM forms trap
                d_illegal = (inst[31:7] != 25'h0) && (inst[31:7] != 25'h2000);
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase

        if (d_illegal) begin
            d_fmt       = FMT_NONE;
            d_alu_op    = ALU_ADD;
            d_src_imm   = 1'b0;
            d_reg_write = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_branch    = 1'b0;
            d_jump      = 1'b0;
        end
    end

    // Immediate assembly for the final format; illegal encodings fall to none and yield 0
    always_comb begin
        d_imm = 32'h0;
        case (d_fmt)
            FMT_I:   d_imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   d_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   d_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   d_imm = {inst[31:12], 12'h0};
            FMT_J:   d_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d_imm = 32'h0;
        endcase
    end

    // Pipeline register; strobes and illegal are qualified by inst_valid, fields always captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o     <= 1'b0;
            opcode      <= 7'h0;
            rd          <= 5'h0;
            funct3      <= 3'h0;
            rs1         <= 5'h0;
            rs2         <= 5'h0;
            funct7      <= 7'h0;
            imm         <= 32'h0;
            fmt         <= FMT_NONE;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            valid_o     <= inst_valid;
            opcode      <= inst[6:0];
            rd          <= inst[11:7];
            funct3      <= inst[14:12];
            rs1         <= inst[19:15];
            rs2         <= inst[24:20];
            funct7      <= inst[31:25];
            imm         <= d_imm;
            fmt         <= d_fmt;
            alu_op      <= d_alu_op;
            alu_src_imm <= d_src_imm;
            reg_write   <= d_reg_write & inst_valid;
            mem_read    <= d_mem_read  & inst_valid;
            mem_write   <= d_mem_write & inst_valid;
            branch      <= d_branch    & inst_valid;
            jump        <= d_jump      & inst_valid;
            illegal     <= d_illegal   & inst_valid;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - directed self-checking bench for decode_unit
module tb_decode_unit;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        valid_o;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    decode_unit dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .valid_o     (valid_o),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm),
        .fmt         (fmt),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Strobe vector {valid_o, reg_write, mem_read, mem_write, branch, jump, illegal, alu_src_imm}
    function automatic logic [31:0] strobes();
        return {24'h0, valid_o, reg_write, mem_read, mem_write, branch, jump, illegal, alu_src_imm};
    endfunction

    task automatic apply(input logic [31:0] i, input logic v);
        inst       = i;
        inst_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        inst       = 32'h002081B3;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_strobes", strobes(), 32'h00);
        chk("reset_fmt",     {29'h0, fmt}, 32'd7);
        chk("reset_imm",     imm, 32'h0);
        chk("reset_rd",      {27'h0, rd}, 32'd0);
        rst = 1'b0;

        // ADD x3,x1,x2
        apply(32'h002081B3, 1'b1);
        chk("add_fields", {rd, rs1, rs2, funct7, funct3, opcode}, {5'd3, 5'd1, 5'd2, 7'h00, 3'd0, 7'h33});
        chk("add_fmt",    {29'h0, fmt}, 32'd0);
        chk("add_alu",    {27'h0, alu_op}, 32'd0);
        chk("add_strobes", strobes(), 32'b1100_0000);
        chk("add_imm",    imm, 32'h0);

        // ADDI x2,x1,0x54
        apply(32'h05408113, 1'b1);
        chk("addi_regs",  {22'h0, rd, rs1}, {22'h0, 5'd2, 5'd1});
        chk("addi_imm",   imm, 32'h00000054);
        chk("addi_fmt",   {29'h0, fmt}, 32'd1);
        chk("addi_strobes", strobes(), 32'b1100_0001);

        // LUI x1,0x23
        apply(32'h000230B7, 1'b1);
        chk("lui_rd",  {27'h0, rd}, 32'd1);
        chk("lui_imm", imm, 32'h00023000);
        chk("lui_alu", {27'h0, alu_op}, 32'd10);
        chk("lui_fmt", {29'h0, fmt}, 32'd4);

        // BNE x2,x1,-8
        apply(32'hFE111CE3, 1'b1);
        chk("bne_fields", {17'h0, rs1, rs2, funct3}, {17'h0, 5'd2, 5'd1, 3'd1});
        chk("bne_imm",    imm, 32'hFFFFFFF8);
        chk("bne_alu",    {27'h0, alu_op}, 32'd1);
        chk("bne_strobes", strobes(), 32'b1000_1000);

        // JAL x4,-8
        apply(32'hFF9FF26F, 1'b1);
        chk("jal_rd",  {27'h0, rd}, 32'd4);
        chk("jal_imm", imm, 32'hFFFFFFF8);
        chk("jal_fmt", {29'h0, fmt}, 32'd5);
        chk("jal_strobes", strobes(), 32'b1100_0100);

        // SUB x4,x2,x1
        apply(32'h40110233, 1'b1);
        chk("sub_f7",  {25'h0, funct7}, 32'h20);
        chk("sub_alu", {27'h0, alu_op}, 32'd1);

        // MUL x4,x2,x1
        apply(32'h02110233, 1'b1);
`ifdef DECODE_M_EXT_EN
        chk("mul_alu",     {27'h0, alu_op}, 32'd16);
        chk("mul_strobes", strobes(), 32'b1100_0000);
`else
        chk("mul_illegal", strobes(), 32'b1000_0010);
        chk("mul_fmt",     {29'h0, fmt}, 32'd7);
`endif

        // SW x2,8(x1)
        apply(32'h0020A423, 1'b1);
        chk("sw_imm",     imm, 32'h00000008);
        chk("sw_fmt",     {29'h0, fmt}, 32'd2);
        chk("sw_strobes", strobes(), 32'b1001_0001);

        // LBU x1,4(x1)
        apply(32'h0040C083, 1'b1);
        chk("lbu_imm",     imm, 32'h00000004);
        chk("lbu_strobes", strobes(), 32'b1110_0001);

        // Load with funct3 3 is unsupported
        apply(32'h0000B003, 1'b1);
        chk("ld_illegal", strobes(), 32'b1000_0010);
        chk("ld_imm",     imm, 32'h0);

        // SRAI x1,x1,3
        apply(32'h4030D093, 1'b1);
        chk("srai_alu", {27'h0, alu_op}, 32'd7);
        chk("srai_imm", imm, 32'h00000403);
        chk("srai_strobes", strobes(), 32'b1100_0001);

        // SLLI with funct7 0x20 is unsupported
        apply(32'h40309093, 1'b1);
        chk("slli_bad", strobes(), 32'b1000_0010);

        // Branch funct3 2 is unsupported
        apply(32'h00002063, 1'b1);
        chk("br_f3_bad", strobes(), 32'b1000_0010);

        // BLTU x1,x2,0
        apply(32'h0020E063, 1'b1);
        chk("bltu_alu", {27'h0, alu_op}, 32'd4);
        chk("bltu_strobes", strobes(), 32'b1000_1000);

        // ECALL, EBREAK legal; other SYSTEM forms unsupported
        apply(32'h00000073, 1'b1);
        chk("ecall", {21'h0, fmt, strobes()[7:0]}, {21'h0, 3'd7, 8'b1000_0000});
        apply(32'h00100073, 1'b1);
        chk("ebreak", strobes(), 32'b1000_0000);
        apply(32'h00200073, 1'b1);
        chk("sys_bad", strobes(), 32'b1000_0010);

        // FENCE
        apply(32'h0FF0000F, 1'b1);
        chk("fence", {21'h0, fmt, strobes()[7:0]}, {21'h0, 3'd7, 8'b1000_0000});

        // Unknown opcode 0x7F
        apply(32'h0000007F, 1'b1);
        chk("op7f", {16'h0, alu_op, fmt, strobes()[7:0]}, {16'h0, 5'd0, 3'd7, 8'b1000_0010});

        // inst_valid low: strobes quiet, fields still captured
        apply(32'h002081B3, 1'b0);
        chk("inv_strobes", strobes() & 32'hFE, 32'h00);
        chk("inv_rd",      {27'h0, rd}, 32'd3);

        // Asynchronous reset in the middle of a cycle
        apply(32'hFF9FF26F, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", strobes(), 32'h00);
        chk("rst_mid_imm",     imm, 32'h0);
        chk("rst_mid_fmt",     {29'h0, fmt}, 32'd7);
        chk("rst_mid_rd",      {27'h0, rd}, 32'd0);
        #2;
        rst = 1'b0;

        // First edge after reset captures normally
        apply(32'h05408113, 1'b1);
        chk("post_rst_imm", imm, 32'h00000054);
        chk("post_rst_strobes", strobes(), 32'b1100_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
